// File: rtl/lcd_ctrl_param.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_ctrl_param
//  Purpose  : HD44780-class character-LCD controller. Sequences the power-up
//             delay and the initialisation command list, then accepts single
//             host writes and times the E strobe. Clock rate, delays and the
//             LCD bus width (8-bit or 4-bit nibble mode) are parameters.
//  Ports    : clk        - rising-edge clock
//             rst_n      - asynchronous active-low reset
//             in_data    - {N, F, D, C, B, I/D, S}, sampled at each init command
//             lcd_enable - host write request (honoured only in READY)
//             lcd_bus    - {rs, rw, data[7:0]} host word
//             e          - LCD enable strobe
//             lcd_data   - LCD data (nibble mode: [7:4] used, [3:0] = 0)
//             rw, rs     - LCD read/write and register select
//             busy       - controller cannot accept a request
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_ctrl_param #(
    parameter int CLK_FREQ   = 20,
    parameter int NIBBLE     = 0,
    parameter int POWERUP_US = 500,
    parameter int CLEAR_US   = 1600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] in_data,
    input  logic       lcd_enable,
    input  logic [9:0] lcd_bus,
    output logic       e,
    output logic [7:0] lcd_data,
    output logic       rw,
    output logic       rs,
    output logic       busy
);

    localparam int F        = 50 * CLK_FREQ;
    localparam int PWR_CYC  = POWERUP_US * CLK_FREQ;
    localparam int CLR_CYC  = CLEAR_US * CLK_FREQ;
    localparam int MAX_WAIT = (PWR_CYC > CLR_CYC) ? PWR_CYC : CLR_CYC;
    // The same counter times both the long waits and the frames.
    localparam int MAX_CNT  = (MAX_WAIT > F) ? MAX_WAIT : F;
    localparam int CW       = $clog2(MAX_CNT + 1);

    localparam logic [CW-1:0] PWR_LAST = CW'(PWR_CYC - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYC - 1);
    localparam logic [CW-1:0] F_LAST   = CW'(F - 1);
    localparam logic [CW-1:0] E_ON     = CW'(CLK_FREQ);
    localparam logic [CW-1:0] E_OFF    = CW'(14 * CLK_FREQ);
    localparam logic          IS_NIB   = (NIBBLE != 0);

    localparam logic [2:0] ST_PWRUP = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_CLRW  = 3'd2;  // idle gap after Display Clear, still part of init
    localparam logic [2:0] ST_READY = 3'd3;
    localparam logic [2:0] ST_SEND  = 3'd4;

    localparam logic [2:0] CMD_NIB   = 3'd0;
    localparam logic [2:0] CMD_FSET  = 3'd1;
    localparam logic [2:0] CMD_DCTL  = 3'd2;
    localparam logic [2:0] CMD_CLR   = 3'd3;
    localparam logic [2:0] CMD_ENTRY = 3'd4;

    function automatic logic [7:0] cmd_byte(input logic [2:0] step, input logic [6:0] cfg);
        case (step)
            CMD_NIB:  cmd_byte = 8'h20;
            CMD_FSET: cmd_byte = {3'b001, ~IS_NIB, cfg[6], cfg[5], 2'b00};
            CMD_DCTL: cmd_byte = {5'b00001, cfg[4:2]};
            CMD_CLR:  cmd_byte = 8'h01;
            default:  cmd_byte = {6'b000001, cfg[1:0]};
        endcase
    endfunction

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    step_q, step_d;
    logic          half_q, half_d;      // 1 while sending the low nibble
    logic [7:0]    byte_q, byte_d;      // byte of the current transfer
    logic [1:0]    rsrw_q, rsrw_d;      // latched {rs, rw} of the host word
    logic          e_q, e_d;
    logic [7:0]    lcd_data_q, lcd_data_d;
    logic          rs_q, rs_d, rw_q, rw_d;
    logic          busy_q, busy_d;
    logic          frame_end, cmd_last, framing;

    // State register (also holds the registered outputs)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_PWRUP;
            cnt_q      <= '0;
            step_q     <= CMD_NIB;
            half_q     <= 1'b0;
            byte_q     <= '0;
            rsrw_q     <= '0;
            e_q        <= 1'b0;
            lcd_data_q <= '0;
            rs_q       <= 1'b0;
            rw_q       <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            half_q     <= half_d;
            byte_q     <= byte_d;
            rsrw_q     <= rsrw_d;
            e_q        <= e_d;
            lcd_data_q <= lcd_data_d;
            rs_q       <= rs_d;
            rw_q       <= rw_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        step_d    = step_q;
        half_d    = half_q;
        byte_d    = byte_q;
        rsrw_d    = rsrw_q;
        frame_end = (cnt_q == F_LAST);
        // The 4-bit switch command is a lone nibble; 8-bit commands are one frame.
        cmd_last  = !IS_NIB || half_q || (step_q == CMD_NIB);

        case (state_q)
            ST_PWRUP: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                    half_d  = 1'b0;
                    step_d  = IS_NIB ? CMD_NIB : CMD_FSET;
                    byte_d  = cmd_byte(step_d, in_data);
                end
            end
            ST_INIT: begin
                if (frame_end) begin
                    cnt_d = '0;
                    if (!cmd_last) begin
                        half_d = 1'b1;
                    end else if (step_q == CMD_CLR) begin
                        state_d = ST_CLRW;
                    end else if (step_q == CMD_ENTRY) begin
                        state_d = ST_READY;
                    end else begin
                        step_d = step_q + 3'd1;
                        half_d = 1'b0;
                        byte_d = cmd_byte(step_d, in_data);
                    end
                end
            end
            ST_CLRW: begin
                if (cnt_q == CLR_LAST) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                    step_d  = CMD_ENTRY;
                    half_d  = 1'b0;
                    byte_d  = cmd_byte(CMD_ENTRY, in_data);
                end
            end
            ST_READY: begin
                cnt_d = '0;
                if (lcd_enable) begin
                    state_d = ST_SEND;
                    half_d  = 1'b0;
                    byte_d  = lcd_bus[7:0];
                    rsrw_d  = lcd_bus[9:8];
                end
            end
            ST_SEND: begin
                if (frame_end) begin
                    cnt_d = '0;
                    if (IS_NIB && !half_q) begin
                        half_d = 1'b1;
                    end else begin
                        state_d = ST_READY;
                    end
                end
            end
            default: begin
                state_d = ST_PWRUP;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: computed from the next state so the pins are registered
    // yet line up with the frame cycle the state register is entering.
    always_comb begin
        framing    = (state_d == ST_INIT) || (state_d == ST_SEND);
        e_d        = framing && (cnt_d >= E_ON) && (cnt_d < E_OFF);
        lcd_data_d = '0;
        rs_d       = 1'b0;
        rw_d       = 1'b0;
        busy_d     = (state_d != ST_READY);
        if (framing) begin
            if (IS_NIB) begin
                lcd_data_d = {(half_d ? byte_d[3:0] : byte_d[7:4]), 4'b0000};
            end else begin
                lcd_data_d = byte_d;
            end
        end
        if (state_d == ST_SEND) begin
            {rs_d, rw_d} = rsrw_d;
        end
    end

    assign e        = e_q;
    assign lcd_data = lcd_data_q;
    assign rw       = rw_q;
    assign rs       = rs_q;
    assign busy     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_ctrl_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lcd_ctrl_param
//  Purpose  : Self-checking bench for lcd_ctrl_param. One 8-bit and one
//             nibble-mode instance share the stimulus. A segment-queue model
//             (idle gaps and frames) predicts every output each cycle; table
//             records and hand sequences check init, writes, rejection,
//             back-to-back throughput and asynchronous reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_ctrl_param;

    localparam int CF = 2;
    localparam int PU = 5;
    localparam int CU = 10;
    localparam int F  = 50 * CF;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] in_data = 7'h7F;
    logic       lcd_enable = 1'b0;
    logic [9:0] lcd_bus = '0;
    logic       e8, rw8, rs8, busy8, en, rwn, rsn, busyn;
    logic [7:0] d8, dn;

    lcd_ctrl_param #(.CLK_FREQ(CF), .NIBBLE(0), .POWERUP_US(PU), .CLEAR_US(CU)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .lcd_enable(lcd_enable),
        .lcd_bus(lcd_bus), .e(e8), .lcd_data(d8), .rw(rw8), .rs(rs8), .busy(busy8));

    lcd_ctrl_param #(.CLK_FREQ(CF), .NIBBLE(1), .POWERUP_US(PU), .CLEAR_US(CU)) dutn (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .lcd_enable(lcd_enable),
        .lcd_bus(lcd_bus), .e(en), .lcd_data(dn), .rw(rwn), .rs(rsn), .busy(busyn));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // ---------------- reference model: queue of timed segments ----------------
    typedef struct packed {
        logic        frame;
        logic [15:0] len;
        logic        rs;
        logic        rw;
        logic [7:0]  d;
    } seg_t;

    seg_t segs [2][16];
    int   hd [2];
    int   tl [2];
    int   off [2];

    function automatic void push(int m, logic fr, int len, logic r_s, logic r_w, logic [7:0] d);
        segs[m][tl[m]] = '{frame: fr, len: 16'(len), rs: r_s, rw: r_w, d: d};
        tl[m]++;
    endfunction

    function automatic void push_byte(int m, logic r_s, logic r_w, logic [7:0] b);
        if (m == 0) begin
            push(m, 1'b1, F, r_s, r_w, b);
        end else begin
            push(m, 1'b1, F, r_s, r_w, {b[7:4], 4'h0});
            push(m, 1'b1, F, r_s, r_w, {b[3:0], 4'h0});
        end
    endfunction

    function automatic void model_reset(int m);
        hd[m] = 0; tl[m] = 0; off[m] = 0;
        push(m, 1'b0, PU * CF, 1'b0, 1'b0, 8'h00);
        if (m == 1) push(m, 1'b1, F, 1'b0, 1'b0, 8'h20);
        push_byte(m, 1'b0, 1'b0, {3'b001, (m == 0), in_data[6], in_data[5], 2'b00});
        push_byte(m, 1'b0, 1'b0, {5'b00001, in_data[4:2]});
        push_byte(m, 1'b0, 1'b0, 8'h01);
        push(m, 1'b0, CU * CF, 1'b0, 1'b0, 8'h00);
        push_byte(m, 1'b0, 1'b0, {6'b000001, in_data[1:0]});
    endfunction

    function automatic void model_step(int m);
        if (hd[m] != tl[m]) begin
            off[m]++;
            if (off[m] == int'(segs[m][hd[m]].len)) begin
                hd[m]++;
                off[m] = 0;
            end
        end else if (lcd_enable) begin
            hd[m] = 0; tl[m] = 0; off[m] = 0;
            push_byte(m, lcd_bus[9], lcd_bus[8], lcd_bus[7:0]);
        end
    endfunction

    // {e, data[7:0], rw, rs, busy}
    function automatic logic [11:0] exp_out(int m);
        seg_t s;
        logic ev;
        if (hd[m] == tl[m]) return 12'h000;
        s = segs[m][hd[m]];
        if (!s.frame) return 12'h001;
        ev = (off[m] >= CF) && (off[m] < 14 * CF);
        return {ev, s.d, s.rw, s.rs, 1'b1};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) model_reset(m);
            else        model_step(m);
        end
    end

    task automatic cmp_dut(input int m, input logic [11:0] act);
        logic [11:0] ex;
        ex = exp_out(m);
        n_vec++;
        if (act !== ex) begin
            n_bad++;
            $display("FAIL model dut%0d t=%0t got e=%b d=%h rw=%b rs=%b busy=%b, want e=%b d=%h rw=%b rs=%b busy=%b",
                     m, $time, act[11], act[10:3], act[2], act[1], act[0],
                     ex[11], ex[10:3], ex[2], ex[1], ex[0]);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut(0, {e8, d8, rw8, rs8, busy8});
            cmp_dut(1, {en, dn, rwn, rsn, busyn});
        end
    end

    // ---------------- hand checks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready(input int lim);
        int k;
        k = 0;
        while ((busy8 || busyn) && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (busy8 || busyn) begin
            n_vec++;
            n_bad++;
            $display("FAIL wait_ready timeout: busy8=%b busyn=%b, want 0 0", busy8, busyn);
        end
    endtask

    typedef struct {
        logic [9:0] bus;
        logic       poke;
        logic [7:0] xd;
        logic       xrs;
        logic       xrw;
    } wr_t;

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0] q8[$];
        logic [7:0] qn[$];
        logic [7:0] x8 [4];
        logic [7:0] xn [9];
        wr_t        wt [4];
        int         fall8, falln, ne8, rise8, risen;
        int         r8[$];
        int         rn[$];
        logic       e8p, enp, b8p, bnp, lownz;

        x8 = '{8'h3C, 8'h0F, 8'h01, 8'h07};
        xn = '{8'h20, 8'h20, 8'hC0, 8'h00, 8'hF0, 8'h00, 8'h10, 8'h00, 8'h70};
        wt[0] = '{bus: 10'h2A5, poke: 1'b0, xd: 8'hA5, xrs: 1'b1, xrw: 1'b0};
        wt[1] = '{bus: 10'h13C, poke: 1'b1, xd: 8'h3C, xrs: 1'b0, xrw: 1'b1};
        wt[2] = '{bus: 10'h000, poke: 1'b1, xd: 8'h00, xrs: 1'b0, xrw: 1'b0};
        wt[3] = '{bus: 10'h3FF, poke: 1'b0, xd: 8'hFF, xrs: 1'b1, xrw: 1'b1};

        // ---- reset state and initialisation sequence ----
        repeat (3) @(negedge clk);
        check("reset_out8", {20'h0, e8, d8, rw8, rs8, busy8}, 32'h001);
        check("reset_outn", {20'h0, en, dn, rwn, rsn, busyn}, 32'h001);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        fall8 = -1; falln = -1; ne8 = 0; e8p = 0; enp = 0; lownz = 0;
        for (int n = 1; n <= 1200 && (fall8 < 0 || falln < 0); n++) begin
            @(negedge clk);
            if (e8 && !e8p) q8.push_back(d8);
            if (en && !enp) qn.push_back(dn);
            e8p = e8; enp = en;
            if (e8) ne8++;
            if (dn[3:0] != 4'h0) lownz = 1'b1;
            if (!busy8 && fall8 < 0) fall8 = n;
            if (!busyn && falln < 0) falln = n;
        end
        check("busy8_fall_cycle", fall8, 430);
        check("busyn_fall_cycle", falln, 930);
        check("e8_high_cycles", ne8, 104);
        check("nibble_low_zero", {31'h0, lownz}, 32'h0);
        check("init8_frames", q8.size(), 4);
        check("initn_frames", qn.size(), 9);
        for (int i = 0; i < 4; i++)
            check($sformatf("init8_byte%0d", i), (i < q8.size()) ? 32'(q8[i]) : 32'hDEAD, 32'(x8[i]));
        for (int i = 0; i < 9; i++)
            check($sformatf("initn_nib%0d", i), (i < qn.size()) ? 32'(qn[i]) : 32'hDEAD, 32'(xn[i]));

        // ---- table-driven host writes, with optional busy-time pokes ----
        for (int i = 0; i < 4; i++) begin
            wait_ready(2000);
            lcd_enable = 1'b1;
            lcd_bus    = wt[i].bus;
            @(negedge clk);                                   // frame cycle 0
            lcd_enable = 1'b0;
            lcd_bus    = 10'($urandom);
            check($sformatf("w%0d_e_c0", i), e8, 0);
            check($sformatf("w%0d_d8_c0", i), d8, wt[i].xd);
            repeat (2) @(negedge clk);                        // c=2
            check($sformatf("w%0d_e_c2", i), {en, e8}, 2'b11);
            repeat (8) @(negedge clk);                        // c=10
            check($sformatf("w%0d_rsrw8", i), {rs8, rw8}, {wt[i].xrs, wt[i].xrw});
            check($sformatf("w%0d_d8", i), d8, wt[i].xd);
            check($sformatf("w%0d_dn_hi", i), dn, {wt[i].xd[7:4], 4'h0});
            check($sformatf("w%0d_rsrwn", i), {rsn, rwn}, {wt[i].xrs, wt[i].xrw});
            if (wt[i].poke) begin
                lcd_enable = 1'b1;
                lcd_bus    = ~wt[i].bus;
            end
            @(negedge clk);                                   // c=11
            lcd_enable = 1'b0;
            repeat (16) @(negedge clk);                       // c=27
            check($sformatf("w%0d_e_c27", i), e8, 1);
            @(negedge clk);                                   // c=28
            check($sformatf("w%0d_e_c28", i), e8, 0);
            repeat (71) @(negedge clk);                       // c=99
            check($sformatf("w%0d_busy8_c99", i), busy8, 1);
            check($sformatf("w%0d_d8_c99", i), d8, wt[i].xd);
            @(negedge clk);                                   // c=100
            check($sformatf("w%0d_busy8_c100", i), {busy8, d8}, 9'h000);
            repeat (10) @(negedge clk);                       // c=110
            check($sformatf("w%0d_dn_lo", i), dn, {wt[i].xd[3:0], 4'h0});
            repeat (89) @(negedge clk);                       // c=199
            check($sformatf("w%0d_busyn_c199", i), busyn, 1);
            @(negedge clk);                                   // c=200
            check($sformatf("w%0d_busyn_c200", i), busyn, 0);
            repeat (5) @(negedge clk);
            check($sformatf("w%0d_no_extra", i), {busy8, busyn}, 2'b00);
        end

        // ---- continuous request: accepted every F+1 / 2F+1 cycles ----
        wait_ready(2000);
        lcd_enable = 1'b1;
        lcd_bus    = 10'h155;
        b8p = 1'b0; bnp = 1'b0;
        for (int n = 0; n < 700; n++) begin
            @(negedge clk);
            if (busy8 && !b8p) r8.push_back(n);
            if (busyn && !bnp) rn.push_back(n);
            b8p = busy8; bnp = busyn;
        end
        lcd_enable = 1'b0;
        check("b2b_n_count_ok", (rn.size() >= 3), 1);
        check("b2b_8_count_ok", (r8.size() >= 6), 1);
        for (int i = 1; i < 3 && i < rn.size(); i++)
            check($sformatf("b2b_n_period%0d", i), rn[i] - rn[i-1], 2 * F + 1);
        for (int i = 1; i < 6 && i < r8.size(); i++)
            check($sformatf("b2b_8_period%0d", i), r8[i] - r8[i-1], F + 1);

        // ---- asynchronous reset mid-frame, then exact power-up timing ----
        wait_ready(2000);
        lcd_enable = 1'b1;
        lcd_bus    = 10'h2A5;
        @(negedge clk);
        lcd_enable = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_reset_e", {en, e8}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset8", {20'h0, e8, d8, rw8, rs8, busy8}, 32'h001);
        check("async_resetn", {20'h0, en, dn, rwn, rsn, busyn}, 32'h001);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rise8 = -1; risen = -1; fall8 = -1;
        for (int n = 1; n <= 1000 && fall8 < 0; n++) begin
            @(negedge clk);
            if (e8 && rise8 < 0) rise8 = n;
            if (en && risen < 0) risen = n;
            if (!busy8 && fall8 < 0) fall8 = n;
        end
        check("rst_first_e8", rise8, PU * CF + CF);
        check("rst_first_en", risen, PU * CF + CF);
        check("rst_busy8_fall", fall8, 430);

        // ---- randomized runs against the model ----
        for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            in_data = 7'($urandom);
            #2 rst_n = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            for (int n = 0; n < 3000; n++) begin
                @(negedge clk);
                lcd_enable = ($urandom_range(0, 29) == 0) || (n > 2600 && n < 2900);
                lcd_bus    = 10'($urandom);
            end
            lcd_enable = 1'b0;
        end
        wait_ready(2000);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
